// File: rtl/swerv_types.sv
// Shared types for the EXU divide arbiter: request record, FSM state
// encoding and the RISC-V divide special-case operand constants.
package swerv_types;

   localparam int DIV_XLEN = 32;
   localparam int DIV_TAGW = 3;

   // One captured divide request; widths come from this package, so the
   // arbiter's XLEN/TAGW parameters must stay equal to these.
   typedef struct packed {
      logic [DIV_XLEN-1:0] rs1;
      logic [DIV_XLEN-1:0] rs2;
      logic                unsign;
      logic                rem;
      logic [DIV_TAGW-1:0] tag;
   } div_req_t;

   typedef enum logic [1:0] {
      DIV_ST_IDLE  = 2'd0,
      DIV_ST_ISSUE = 2'd1,
      DIV_ST_BUSY  = 2'd2,
      DIV_ST_RESP  = 2'd3
   } div_arb_state_t;

   localparam logic [DIV_XLEN-1:0] DIV_MIN_INT = 32'h8000_0000;
   localparam logic [DIV_XLEN-1:0] DIV_NEG_ONE = 32'hFFFF_FFFF;

endpackage

// File: rtl/exu_div_arb_rr.sv
// Two-way round-robin grant for the divide arbiter. The pointer names the
// slot favoured on a tie and flips away from whichever slot was granted.
module exu_div_rr_arb (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic ptr_q;

   // Grant: single requester wins, a tie goes to the pointer slot.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      gnt = 2'b00;
      if (en) begin
         case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // Pointer moves to the other slot on every grant (grant implies handshake).
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst)       ptr_q <= 1'b0;
      else if (|gnt) ptr_q <= ~gnt[1];
   end

endmodule

// File: rtl/exu_div_arb.sv
// EXU divide arbiter/sequencer: shares one iterative divider between the
// I0 and I1 slots, launches it, watches for completion with a watchdog and
// returns a tagged result to DEC.
// Optional build macro EXU_DIV_SPECIAL_EN: resolve divide-by-zero and signed
// overflow in ISSUE without starting the divider.
module exu_div_arb
   import swerv_types::*;
#(
   parameter int XLEN    = DIV_XLEN,
   parameter int TAGW    = DIV_TAGW,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req_valid,
   output logic [1:0]        req_ready,
   input  logic [2*XLEN-1:0] req_rs1,
   input  logic [2*XLEN-1:0] req_rs2,
   input  logic [1:0]        req_unsign,
   input  logic [1:0]        req_rem,
   input  logic [2*TAGW-1:0] req_tag,
   input  logic              flush,
   output logic              div_start,
   output logic              div_cancel,
   output logic [XLEN-1:0]   div_a,
   output logic [XLEN-1:0]   div_b,
   output logic              div_unsign,
   output logic              div_rem,
   input  logic              div_finish,
   input  logic [XLEN-1:0]   div_result,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_data,
   output logic [TAGW-1:0]   resp_tag,
   output logic              resp_slot,
   output logic              resp_err,
   output logic              div_stall
);

   localparam logic [1:0] ST_IDLE  = DIV_ST_IDLE;
   localparam logic [1:0] ST_ISSUE = DIV_ST_ISSUE;
   localparam logic [1:0] ST_BUSY  = DIV_ST_BUSY;
   localparam logic [1:0] ST_RESP  = DIV_ST_RESP;

   localparam int              CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0]   TMAX = CW'(TIMEOUT - 1);

   logic [1:0]      state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   div_req_t        cap_q, cap_d;
   logic            slot_q, slot_d;
   logic [XLEN-1:0] resp_data_q, resp_data_d;
   logic            resp_err_q, resp_err_d;

   logic [1:0]      gnt;
   logic            accept;
   logic            sel;
   logic            special;
   logic [XLEN-1:0] special_res;

   exu_div_rr_arb u_rr (
      .clk (clk),
      .rst (rst),
      .en  ((state_q == ST_IDLE) && !flush),
      .req (req_valid),
      .gnt (gnt)
   );

   assign req_ready = gnt;
   assign accept    = |(req_valid & req_ready);
   assign sel       = gnt[1];

`ifdef EXU_DIV_SPECIAL_EN
   // Special-case detection on the captured operands while in ISSUE.
   always_comb begin
      special     = 1'b0;
      special_res = '0;
      if (cap_q.rs2 == '0) begin
         special     = 1'b1;
         special_res = cap_q.rem ? cap_q.rs1 : '1;
      end else if (!cap_q.unsign && (cap_q.rs1 == DIV_MIN_INT) &&
                   (cap_q.rs2 == DIV_NEG_ONE)) begin
         special     = 1'b1;
         special_res = cap_q.rem ? '0 : DIV_MIN_INT;
      end
   end
`else
   assign special     = 1'b0;
   assign special_res = '0;
`endif

   // Next-state, capture and divider-control decode for the sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cap_d       = cap_q;
      slot_d      = slot_q;
      resp_data_d = resp_data_q;
      resp_err_d  = resp_err_q;
      div_start   = 1'b0;
      div_cancel  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cap_d.rs1    = sel ? req_rs1[2*XLEN-1:XLEN] : req_rs1[XLEN-1:0];
               cap_d.rs2    = sel ? req_rs2[2*XLEN-1:XLEN] : req_rs2[XLEN-1:0];
               cap_d.unsign = req_unsign[sel];
               cap_d.rem    = req_rem[sel];
               cap_d.tag    = sel ? req_tag[2*TAGW-1:TAGW] : req_tag[TAGW-1:0];
               slot_d       = sel;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d = '0;
            if (flush) begin
               div_cancel = 1'b1;
               state_d    = ST_IDLE;
            end else if (special) begin
               resp_data_d = special_res;
               resp_err_d  = 1'b0;
               state_d     = ST_RESP;
            end else begin
               div_start = 1'b1;
               state_d   = ST_BUSY;
            end
         end
         ST_BUSY: begin
            // Flush outranks a same-cycle finish, which outranks the watchdog.
            if (flush) begin
               div_cancel = 1'b1;
               state_d    = ST_IDLE;
            end else if (div_finish) begin
               resp_data_d = div_result;
               resp_err_d  = 1'b0;
               state_d     = ST_RESP;
            end else if (cnt_q == TMAX) begin
               div_cancel  = 1'b1;
               resp_data_d = '0;
               resp_err_d  = 1'b1;
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RESP: begin
            if (flush || resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State, watchdog, capture and response registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         cap_q       <= '0;
         slot_q      <= 1'b0;
         resp_data_q <= '0;
         resp_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cap_q       <= cap_d;
         slot_q      <= slot_d;
         resp_data_q <= resp_data_d;
         resp_err_q  <= resp_err_d;
      end
   end

   assign div_a      = cap_q.rs1;
   assign div_b      = cap_q.rs2;
   assign div_unsign = cap_q.unsign;
   assign div_rem    = cap_q.rem;

   // A flush in RESP withdraws the response in the same cycle.
   assign resp_valid = (state_q == ST_RESP) && !flush;
   assign resp_data  = resp_data_q;
   assign resp_tag   = cap_q.tag;
   assign resp_slot  = slot_q;
   assign resp_err   = resp_err_q;
   assign div_stall  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exu_div_arb.sv
// Self-checking bench for exu_div_arb with a stub iterative divider.
// Build with EXU_DIV_SPECIAL_EN defined to also exercise the special cases.
module tb_exu_div_arb;

   localparam int XLEN = 32;
   localparam int TAGW = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [2*XLEN-1:0] req_rs1, req_rs2;
   logic [1:0]        req_unsign, req_rem;
   logic [2*TAGW-1:0] req_tag;
   logic              flush;
   logic              div_start, div_cancel;
   logic [XLEN-1:0]   div_a, div_b;
   logic              div_unsign, div_rem;
   logic              div_finish;
   logic [XLEN-1:0]   div_result;
   logic              resp_valid, resp_ready;
   logic [XLEN-1:0]   resp_data;
   logic [TAGW-1:0]   resp_tag;
   logic              resp_slot, resp_err, div_stall;

   exu_div_arb #(.XLEN(XLEN), .TAGW(TAGW), .TIMEOUT(64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rs1(req_rs1), .req_rs2(req_rs2),
      .req_unsign(req_unsign), .req_rem(req_rem), .req_tag(req_tag),
      .flush(flush),
      .div_start(div_start), .div_cancel(div_cancel),
      .div_a(div_a), .div_b(div_b),
      .div_unsign(div_unsign), .div_rem(div_rem),
      .div_finish(div_finish), .div_result(div_result),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag),
      .resp_slot(resp_slot), .resp_err(resp_err),
      .div_stall(div_stall)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Stub divider: finishes stub_k cycles after div_start (0 = never).
   int              stub_k = 0;
   int              stub_cnt;
   logic            stub_busy;
   logic [XLEN-1:0] stub_res;
   logic            stub_fin;
   logic            force_fin = 1'b0;

   function automatic logic [XLEN-1:0] ref_div(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                                logic uns, logic rem);
      logic signed [XLEN-1:0] sa, sb;
      sa = a;
      sb = b;
      if (b == '0) return '0;
      if (uns) return rem ? (a % b) : (a / b);
      return rem ? XLEN'(sa % sb) : XLEN'(sa / sb);
   endfunction

   assign stub_fin   = stub_busy && (stub_k > 0) && (stub_cnt == stub_k);
   assign div_finish = stub_fin | force_fin;
   assign div_result = stub_res;

   always @(posedge clk) begin
      if (rst) begin
         stub_busy <= 1'b0;
         stub_cnt  <= 0;
         stub_res  <= '0;
      end else if (div_cancel) begin
         stub_busy <= 1'b0;
      end else if (div_start) begin
         stub_busy <= 1'b1;
         stub_cnt  <= 1;
         stub_res  <= ref_div(div_a, div_b, div_unsign, div_rem);
      end else if (stub_busy) begin
         if (stub_fin) stub_busy <= 1'b0;
         stub_cnt <= stub_cnt + 1;
      end
   end

   typedef struct {
      logic [1:0]      vmask;
      int              slot;
      logic [XLEN-1:0] rs1;
      logic [XLEN-1:0] rs2;
      logic            uns;
      logic            rem;
      logic [TAGW-1:0] tag;
      int              k;
      int              hold;
      logic [XLEN-1:0] exp_data;
      logic            exp_err;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] data;
      logic [TAGW-1:0] tag;
      logic            slot;
      logic            err;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      for (int s = 0; s < 2; s++) begin
         if (s == v.slot) begin
            req_rs1[s*XLEN +: XLEN] = v.rs1;
            req_rs2[s*XLEN +: XLEN] = v.rs2;
            req_unsign[s]           = v.uns;
            req_rem[s]              = v.rem;
            req_tag[s*TAGW +: TAGW] = v.tag;
         end else begin
            req_rs1[s*XLEN +: XLEN] = ~v.rs1;
            req_rs2[s*XLEN +: XLEN] = v.rs2 + 1;
            req_unsign[s]           = ~v.uns;
            req_rem[s]              = ~v.rem;
            req_tag[s*TAGW +: TAGW] = ~v.tag;
         end
      end
   endtask

   // Present a request, wait for its handshake, optionally score it, and
   // check the ISSUE cycle that follows.
   task automatic issue(input vec_t v, input bit exp_start, input bit push, output int acc);
      drive(v);
      req_valid = v.vmask;
      acc = -1;
      for (int t = 0; t < 8; t++) begin
         #1;
         if ((req_valid & req_ready) != 2'b00) begin
            acc = cyc;
            break;
         end
         @(negedge clk);
      end
      if (acc < 0) begin
         check("accept_timeout", 0, 1);
         req_valid = 2'b00;
         return;
      end
      check("grant", req_ready, 64'(2'b01 << v.slot));
      if (push) sb.push_back('{v.exp_data, v.tag, 1'(v.slot), v.exp_err});
      step();
      check("div_start", div_start, exp_start);
      check("stall_issue", div_stall, 1);
      check("div_a", div_a, v.rs1);
      check("div_b", div_b, v.rs2);
   endtask

   // Wait for the response (checking no re-grant / no re-start meanwhile),
   // hold it, then handshake and compare against the scoreboard.
   task automatic complete(input int acc, input int lat, input int cancel_at,
                           input int hold, output int hs);
      int              got;
      logic [XLEN-1:0] d0;
      logic [TAGW-1:0] t0;
      exp_t            e;
      got = -1;
      hs  = -1;
      req_valid = 2'b11;
      for (int t = 0; t < 200; t++) begin
         step();
         check("no_grant_busy", req_ready, 0);
         check("no_restart", div_start, 0);
         if (cancel_at >= 0) check("cancel_time", div_cancel, 64'(cyc == cancel_at));
         if (resp_valid) begin
            got = cyc;
            break;
         end
      end
      if (got < 0) begin
         check("resp_timeout", 0, 1);
         req_valid = 2'b00;
         return;
      end
      check("latency", 64'(got - acc), 64'(lat));
      d0 = resp_data;
      t0 = resp_tag;
      for (int h = 0; h < hold; h++) begin
         step();
         check("hold_valid", resp_valid, 1);
         check("hold_data", resp_data, d0);
         check("hold_tag", resp_tag, t0);
         check("hold_no_grant", req_ready, 0);
      end
      resp_ready = 1'b1;
      hs = cyc;
      if (sb.size() == 0) begin
         check("sb_nonempty", 0, 1);
      end else begin
         e = sb.pop_front();
         check("resp_data", resp_data, e.data);
         check("resp_tag", resp_tag, e.tag);
         check("resp_slot", resp_slot, e.slot);
         check("resp_err", resp_err, e.err);
      end
      step();
      resp_ready = 1'b0;
      req_valid  = 2'b00;
      check("resp_drop", resp_valid, 0);
      check("idle_after", div_stall, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t tbl[7];
      vec_t v;
      int   acc, hs, prev_hs;

      tbl[0] = '{2'b01, 0, 32'h0000_0100, 32'h0000_0002, 1'b1, 1'b0, 3'd5, 34, 0, 32'h0000_0080, 1'b0};
      tbl[1] = '{2'b11, 1, 32'd100,       32'd7,         1'b1, 1'b1, 3'd3,  5, 0, 32'd2,         1'b0};
      tbl[2] = '{2'b11, 0, 32'hFFFF_FFEC, 32'd3,         1'b0, 1'b0, 3'd1,  3, 0, 32'hFFFF_FFFA, 1'b0};
      tbl[3] = '{2'b10, 1, 32'hFFFF_FFEC, 32'd3,         1'b0, 1'b1, 3'd6,  1, 5, 32'hFFFF_FFFE, 1'b0};
      tbl[4] = '{2'b11, 0, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 1'b0, 3'd7,  2, 0, 32'h0FFF_FFFF, 1'b0};
      tbl[5] = '{2'b01, 0, 32'd7,         32'd9,         1'b1, 1'b1, 3'd0, 10, 2, 32'd7,         1'b0};
      tbl[6] = '{2'b11, 1, 32'd100,       32'hFFFF_FFF9, 1'b0, 1'b0, 3'd2,  4, 0, 32'hFFFF_FFF2, 1'b0};

      rst        = 1'b1;
      req_valid  = 2'b00;
      req_rs1    = '0;
      req_rs2    = '0;
      req_unsign = '0;
      req_rem    = '0;
      req_tag    = '0;
      flush      = 1'b0;
      resp_ready = 1'b0;
      repeat (3) @(posedge clk);
      step();
      check("rst_ready", req_ready, 0);
      check("rst_stall", div_stall, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_start", div_start, 0);
      check("rst_cancel", div_cancel, 0);
      check("rst_resp_data", resp_data, 0);
      check("rst_div_a", div_a, 0);
      check("rst_resp_tag", resp_tag, 0);
      rst = 1'b0;
      step();

      // Table: single/dual requesters, round-robin order, back-to-back, hold.
      prev_hs = -1;
      for (int i = 0; i < 7; i++) begin
         stub_k = tbl[i].k;
         issue(tbl[i], 1'b1, 1'b1, acc);
         if (i > 0) check("back_to_back", 64'(acc), 64'(prev_hs + 1));
         complete(acc, tbl[i].k + 2, -1, tbl[i].hold, hs);
         prev_hs = hs;
      end

      // Flush in IDLE blocks acceptance.
      v = '{2'b01, 0, 32'd50, 32'd5, 1'b1, 1'b0, 3'd4, 3, 0, 32'd10, 1'b0};
      drive(v);
      req_valid = 2'b01;
      flush     = 1'b1;
      #1;
      check("flush_idle_ready", req_ready, 0);
      step();
      check("flush_idle_stall", div_stall, 0);
      flush     = 1'b0;
      req_valid = 2'b00;
      step();

      // Flush in BUSY cycle 10 with a simultaneous div_finish.
      stub_k = 0;
      issue(v, 1'b1, 1'b0, acc);
      req_valid = 2'b00;
      repeat (11) step();
      flush     = 1'b1;
      force_fin = 1'b1;
      #1;
      check("flush_cancel", div_cancel, 1);
      check("flush_no_resp", resp_valid, 0);
      step();
      flush     = 1'b0;
      force_fin = 1'b0;
      check("flush_idle_next", div_stall, 0);
      check("flush_cancel_once", div_cancel, 0);
      for (int t = 0; t < 4; t++) begin
         step();
         check("flush_no_resp_later", resp_valid, 0);
      end
      check("flush_sb_empty", 64'(sb.size()), 0);

      // Watchdog: divider never finishes; cancel at BUSY cycle 63.
      stub_k = 0;
      v = '{2'b01, 0, 32'd9, 32'd3, 1'b1, 1'b0, 3'd6, 0, 0, 32'd0, 1'b1};
      issue(v, 1'b1, 1'b1, acc);
      complete(acc, 66, acc + 65, 0, hs);

`ifdef EXU_DIV_SPECIAL_EN
      // Special cases resolved without the divider.
      v = '{2'b01, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 3'd2, 0, 0, 32'h8000_0000, 1'b0};
      issue(v, 1'b0, 1'b1, acc);
      complete(acc, 2, acc + 200, 0, hs);
      v = '{2'b10, 1, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b1, 3'd3, 0, 0, 32'h0000_1234, 1'b0};
      issue(v, 1'b0, 1'b1, acc);
      complete(acc, 2, acc + 200, 0, hs);
`endif

      check("sb_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
